// File: rtl/toggle_pair_receiver.sv
// Link monitor for a complementary toggle pair: validates q/z, counts toggles,
// flags stuck lines and reports per-window toggle totals over valid/ready.
module toggle_pair_receiver #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned WINDOW      = 64,
    parameter int unsigned STUCK_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_in,
    input  logic             z_in,
    input  logic             clear,
    output logic             toggle_pulse,
    output logic [CNT_W-1:0] toggle_count,
    output logic             stuck,
    output logic             pair_error,
    output logic [1:0]       state,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_overrun
);

    localparam int unsigned WinW  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned IdleW = $clog2(STUCK_LIMIT + 1);

    localparam logic [WinW-1:0]  WinLast   = WinW'(WINDOW - 1);
    localparam logic [IdleW-1:0] IdleLimit = IdleW'(STUCK_LIMIT);
    localparam logic [IdleW-1:0] IdleLast  = IdleW'(STUCK_LIMIT - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StTrack = 2'd1,
        StError = 2'd2
    } state_e;

    state_e            st_q;
    logic              q_s, z_s, q_p, v_s;
    logic [WinW-1:0]   win_cnt_q;
    logic [CNT_W-1:0]  win_tot_q;
    logic [IdleW-1:0]  idle_cnt_q;

    logic              vld;
    logic              tog;
    logic              win_end;
    logic              xfer;
    logic [CNT_W-1:0]  win_sum;
    logic [CNT_W-1:0]  cnt_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        vld     = q_s ^ z_s;
        // A toggle needs a valid pair both now and one sample earlier.
        tog     = (st_q == StTrack) && vld && v_s && (q_s != q_p);
        win_end = (win_cnt_q == WinLast);
        xfer    = rpt_valid && rpt_ready;
        win_sum = sat_inc(win_tot_q, tog);
        cnt_inc = sat_inc(toggle_count, tog);
    end

    assign state = st_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q         <= StIdle;
            q_s          <= 1'b0;
            z_s          <= 1'b0;
            q_p          <= 1'b0;
            v_s          <= 1'b0;
            win_cnt_q    <= '0;
            win_tot_q    <= '0;
            idle_cnt_q   <= '0;
            toggle_pulse <= 1'b0;
            toggle_count <= '0;
            stuck        <= 1'b0;
            pair_error   <= 1'b0;
            rpt_valid    <= 1'b0;
            rpt_count    <= '0;
            rpt_overrun  <= 1'b0;
        end else begin
            q_s          <= q_in;
            z_s          <= z_in;
            q_p          <= q_s;
            v_s          <= vld;
            toggle_pulse <= 1'b0;
            if (clear) begin
                st_q         <= StIdle;
                toggle_count <= '0;
                win_cnt_q    <= '0;
                win_tot_q    <= '0;
                idle_cnt_q   <= '0;
                stuck        <= 1'b0;
                pair_error   <= 1'b0;
                rpt_valid    <= 1'b0;
                rpt_overrun  <= 1'b0;
            end else begin
                case (st_q)
                    StIdle: begin
                        if (xfer) rpt_valid <= 1'b0;
                        if (vld) begin
                            st_q       <= StTrack;
                            idle_cnt_q <= '0;
                            win_cnt_q  <= '0;
                            win_tot_q  <= '0;
                        end
                    end
                    StTrack: begin
                        if (!vld) begin
                            st_q       <= StError;
                            pair_error <= 1'b1;
                        end else begin
                            toggle_pulse <= tog;
                            if (tog) begin
                                toggle_count <= cnt_inc;
                                idle_cnt_q   <= '0;
                                stuck        <= 1'b0;
                            end else if (idle_cnt_q != IdleLimit) begin
                                idle_cnt_q <= idle_cnt_q + 1'b1;
                                if (idle_cnt_q == IdleLast) stuck <= 1'b1;
                            end
                            if (win_end) begin
                                win_cnt_q <= '0;
                                win_tot_q <= CNT_W'(tog);
                                // A pending, unaccepted report wins; the new total is lost.
                                if (!rpt_valid || rpt_ready) begin
                                    rpt_count <= win_sum;
                                    rpt_valid <= 1'b1;
                                end else begin
                                    rpt_overrun <= 1'b1;
                                end
                            end else begin
                                win_cnt_q <= win_cnt_q + 1'b1;
                                win_tot_q <= win_sum;
                                if (xfer) rpt_valid <= 1'b0;
                            end
                        end
                    end
                    StError: begin
                        st_q <= StError;
                    end
                    default: begin
                        st_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_toggle_pair_receiver.sv
// Directed bench for toggle_pair_receiver: vector table for counting/error/clear,
// hand sequences for stuck, window reporting, saturation and reset.
module tb_toggle_pair_receiver;

    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset, q_in, z_in, clear, rpt_ready;
    logic             toggle_pulse, stuck, pair_error, rpt_valid, rpt_overrun;
    logic [CNT_W-1:0] toggle_count, rpt_count;
    logic [1:0]       state;

    int tests = 0;
    int fails = 0;

    toggle_pair_receiver #(
        .CNT_W(CNT_W),
        .WINDOW(8),
        .STUCK_LIMIT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .q_in(q_in),
        .z_in(z_in),
        .clear(clear),
        .toggle_pulse(toggle_pulse),
        .toggle_count(toggle_count),
        .stuck(stuck),
        .pair_error(pair_error),
        .state(state),
        .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready),
        .rpt_count(rpt_count),
        .rpt_overrun(rpt_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic q;
        logic z;
        logic clr;
        int   st;
        int   pulse;
        int   cnt;
        int   perr;
    } vec_t;

    vec_t vecs[19];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " state"}, int'(state), 0);
        chk({tag, " toggle_pulse"}, int'(toggle_pulse), 0);
        chk({tag, " toggle_count"}, int'(toggle_count), 0);
        chk({tag, " stuck"}, int'(stuck), 0);
        chk({tag, " pair_error"}, int'(pair_error), 0);
        chk({tag, " rpt_valid"}, int'(rpt_valid), 0);
        chk({tag, " rpt_count"}, int'(rpt_count), 0);
        chk({tag, " rpt_overrun"}, int'(rpt_overrun), 0);
    endtask

    task automatic drive_pair(input logic q);
        q_in = q;
        z_in = ~q;
    endtask

    initial begin
        // q, z, clear, state, pulse, count, pair_error
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1, 0, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1, 1, 1, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 1, 1, 2, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1, 1, 3, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1, 1, 4, 0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1, 1, 5, 0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1, 1, 6, 0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1, 1, 7, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1, 1, 8, 0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1, 1, 9, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1, 1, 10, 0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1, 0, 10, 0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 2, 0, 10, 1};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 2, 0, 10, 1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 2, 0, 10, 1};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 0, 0, 0, 0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1, 0, 0, 0};

        // Reset with q toggling
        reset = 1'b1; clear = 1'b0; rpt_ready = 1'b1;
        drive_pair(1'b0);
        tick();
        chk_all_zero("reset1");
        drive_pair(1'b1);
        tick();
        reset = 1'b0;

        // Counting, error freeze, clear recovery
        for (int i = 0; i < 19; i++) begin
            q_in  = vecs[i].q;
            z_in  = vecs[i].z;
            clear = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d state", i), int'(state), vecs[i].st);
            chk($sformatf("vec%0d pulse", i), int'(toggle_pulse), vecs[i].pulse);
            chk($sformatf("vec%0d count", i), int'(toggle_count), vecs[i].cnt);
            chk($sformatf("vec%0d pair_error", i), int'(pair_error), vecs[i].perr);
        end
        clear = 1'b0;

        // Stuck: pair held for 16 TRACK cycles
        for (int i = 0; i < 15; i++) tick();
        chk("stuck after 15", int'(stuck), 0);
        tick();
        chk("stuck after 16", int'(stuck), 1);
        drive_pair(1'b0);
        tick();
        chk("stuck held", int'(stuck), 1);
        chk("stuck pulse early", int'(toggle_pulse), 0);
        tick();
        chk("stuck cleared", int'(stuck), 0);
        chk("stuck toggle pulse", int'(toggle_pulse), 1);
        chk("stuck toggle count", int'(toggle_count), 1);

        // Window reporting with an unready consumer
        clear = 1'b1;
        tick();
        clear = 1'b0; rpt_ready = 1'b0;
        chk("win clear rpt_valid", int'(rpt_valid), 0);
        tick();
        chk("win entry state", int'(state), 1);
        for (int t = 1; t <= 7; t++) begin
            if (t <= 5) drive_pair(t[0]);
            tick();
        end
        chk("win pre-end rpt_valid", int'(rpt_valid), 0);
        tick();
        chk("win1 rpt_valid", int'(rpt_valid), 1);
        chk("win1 rpt_count", int'(rpt_count), 5);
        for (int t = 9; t <= 15; t++) tick();
        chk("win2 pre overrun", int'(rpt_overrun), 0);
        chk("win2 pre rpt_valid", int'(rpt_valid), 1);
        tick();
        chk("win2 overrun", int'(rpt_overrun), 1);
        chk("win2 rpt_count kept", int'(rpt_count), 5);
        chk("win2 rpt_valid", int'(rpt_valid), 1);
        rpt_ready = 1'b1;
        tick();
        chk("handshake rpt_valid", int'(rpt_valid), 0);
        chk("handshake overrun sticky", int'(rpt_overrun), 1);

        // Saturation, then reset mid-window
        rpt_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        for (int t = 1; t <= 20; t++) begin
            drive_pair(~q_in);
            tick();
            if (t == 15) chk("sat count 14", int'(toggle_count), 14);
            if (t == 16) chk("sat count 15", int'(toggle_count), 15);
        end
        tick();
        tick();
        chk("sat count held", int'(toggle_count), 15);
        chk("sat rpt_count", int'(rpt_count), 7);
        chk("sat overrun", int'(rpt_overrun), 1);
        reset = 1'b1;
        tick();
        chk_all_zero("reset mid-window");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("post-reset state", int'(state), 1);
        chk("post-reset rpt_valid", int'(rpt_valid), 0);
        chk("post-reset overrun", int'(rpt_overrun), 0);
        chk("post-reset count", int'(toggle_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
